mm2x2_uart_host: RTL
====================

Name: mm2x2_uart_host

Overview:
Host-side initiator for the 2x2 matrix-multiply UART peripheral. It takes A and B operands on a parallel load interface and serializes the 8 operand bytes on its UART TX line. It then deserializes the 4 result bytes returned on its UART RX line and presents them as one 32-bit word. It is used as the on-chip driver and bench model for the multiplier, and it includes a response timeout.

Parameters:
CLKS_PER_BIT, 833, clocks per UART bit (100 MHz / 120000 baud); must be >= 4.
TIMEOUT_CLKS, 100000, idle clocks allowed between arming/received bytes before the transaction is aborted.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  request pulse; accepted only when busy=0
a_flat  in  32  A0=[7:0], A1=[15:8], A2=[23:16], A3=[31:24]; sampled on accepted start
b_flat  in  32  B0..B3, same packing
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at transaction end (success or timeout)
timeout_err  out  1  one-cycle pulse coincident with done on timeout
frame_err  out  1  one-cycle pulse coincident with done on stop-bit error (macro only)
c_flat  out  32  C00=[7:0], C01=[15:8], C10=[23:16], C11=[31:24]
tx_serial  out  1  UART TX line, idle high
rx_serial  in  1  UART RX line, asynchronous

Behaviour:
- Reset values: busy=0, done=0, timeout_err=0, frame_err=0, c_flat=0, tx_serial=1. All state and counters are cleared. Reset mid-frame forces tx_serial=1 immediately.
- Accepted start with busy=0: a_flat and b_flat are latched into an 8-byte shift buffer and busy=1 on the next edge. start while busy=1 is ignored.
- TX framing: 8N1, LSB first. Each bit lasts exactly CLKS_PER_BIT clocks. The start bit begins the cycle after busy rises.
- TX byte order is A0,A1,A2,A3,B0,B1,B2,B3. Frames are back-to-back: the next start bit follows the stop bit with no gap.
- States: IDLE -> TX_START -> TX_DATA(8 bits) -> TX_STOP -> (byte_idx<7 ? TX_START : RX_WAIT) -> IDLE.
- RX arming: RX capture arms on the first cycle of the 8th stop bit, because the responder may answer before that stop bit ends. Bytes seen before arming are discarded.
- RX path:
  - 2-FF synchronizer on rx_serial.
  - Falling edge starts a frame; the start bit is re-checked at CLKS_PER_BIT/2. If it reads high, it is a false start and the receiver returns to idle.
  - Data bits are sampled mid-bit. The byte is valid at mid-stop-bit.
- Result capture: received bytes fill shadow[0..3] in order. On the 4th byte, c_flat <= shadow (atomic update). done pulses the same cycle c_flat updates, busy drops, and the state returns to IDLE.
- Timeout: the counter resets on arming and on each received byte. When it reaches TIMEOUT_CLKS with fewer than 4 bytes received:
  - done and timeout_err pulse together, c_flat is unchanged, and the state returns to IDLE.
  - The RX deserializer is forced idle, including if a frame is in progress.
- Extra RX bytes arriving while IDLE are ignored.
- A new start may be accepted the cycle after done.

Optional Feature:
MM2X2_HOST_FRAME_CHECK_EN
- Defined: the stop bit is sampled. If it reads 0, the byte is dropped, done and frame_err pulse, c_flat is unchanged, and the state returns to IDLE.
- Undefined: the stop bit is not checked, and frame_err is tied to 0.

Decomposition:
- Package mm2x2_host_pkg holds:
  - the state enum;
  - NUM_OPERAND_BYTES=8 and NUM_RESULT_BYTES=4;
  - DEFAULT_CLKS_PER_BIT=833.
- Sub-module mm2x2_host_uart_rx: synchronizer, mid-bit sampler, byte_valid/byte_data/stop_ok outputs, plus a clear input for timeout abort.
- TX shifter and sequencing stay in the top.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_CLKS=2000; responder is the multiplier design or a behavioural model):
- A=[1,2,3,4], B=[5,6,7,8] -> TX bytes 01,02,03,04,05,06,07,08 in order; c_flat=0x322B1613; done and timeout_err=0.
- A=B=[FF,FF,FF,FF] -> each result truncated to 0x02; c_flat=0x02020202.
- TX timing: check the first frame of A0=0x01 -> line is 0,1,0,0,0,0,0,0,0,1, each bit exactly 8 clocks; no gap between frames; busy is held throughout.
- Responder sends only 0x13,0x16 -> done and timeout_err pulse 2000 clocks after the 2nd byte; c_flat keeps its prior value.
- start asserted again mid-transaction with different operands -> ignored; the TX byte stream and result match the first operands only.
- rst_n low during TX_DATA of byte 3 -> tx_serial=1 and busy=0 immediately; a new start afterwards gives a full correct transaction. With MM2X2_HOST_FRAME_CHECK_EN defined, a response stop bit of 0 gives done and frame_err.

Source files
------------

// File: rtl/mm2x2_host_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply UART host.
package mm2x2_host_pkg;
  localparam int NUM_OPERAND_BYTES    = 8;
  localparam int NUM_RESULT_BYTES     = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 833;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_START,
    ST_TX_DATA,
    ST_TX_STOP,
    ST_RX_WAIT
  } host_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;
endpackage

// File: rtl/mm2x2_host_uart_rx.sv
// 8N1 UART deserializer: 2-FF synchronizer, mid-bit sampling, stop-bit status.
module mm2x2_host_uart_rx
  import mm2x2_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       rx_serial,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_ok
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  rx_state_t     state, state_nxt;
  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          half, full;

  assign half = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign full = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (!sync2) state_nxt = RX_START;
      // A start bit that has gone high again by mid-bit was a glitch.
      RX_START: if (half) state_nxt = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (full) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
    if (clear) state_nxt = RX_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      stop_ok    <= 1'b0;
    end else begin
      sync1      <= rx_serial;
      sync2      <= sync1;
      byte_valid <= 1'b0;
      // Every state change restarts the bit timer so phases stay aligned to mid-bit.
      if (state_nxt != state || state == RX_IDLE || full) cnt <= '0;
      else                                               cnt <= cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && full) begin
        byte_data <= {sync2, byte_data[7:1]};
        bit_idx   <= bit_idx + 1'b1;
      end
      if (state == RX_STOP && full && !clear) begin
        byte_valid <= 1'b1;
        stop_ok    <= sync2;
      end
    end
  end
endmodule

// File: rtl/mm2x2_uart_host.sv
// UART host for the 2x2 matrix multiplier: sends A/B operands, collects the 4-byte result.
// Define MM2X2_HOST_FRAME_CHECK_EN to abort on a response stop bit that reads 0.
module mm2x2_uart_host
  import mm2x2_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_flat,
  input  logic [31:0] b_flat,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        frame_err,
  output logic [31:0] c_flat,
  output logic        tx_serial,
  input  logic        rx_serial
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
`ifdef MM2X2_HOST_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  host_state_t   state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx, byte_idx;
  logic [63:0]   tx_buf;
  logic          armed;
  logic [1:0]    rx_cnt;
  logic [23:0]   shadow;
  logic [TW-1:0] tcnt;
  logic          tx_nxt;
  logic          byte_valid, stop_ok;
  logic [7:0]    byte_data;
  logic          bit_end, last_byte, arm_now, take, bad_stop, good_byte, finish_ok, tmo;

  mm2x2_host_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (tmo),
    .rx_serial  (rx_serial),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_ok    (stop_ok)
  );

  assign bit_end   = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == 3'(NUM_OPERAND_BYTES - 1));
  // tx_serial lags state by one register, so this is the first stop-bit cycle on the wire.
  assign arm_now   = (state == ST_TX_STOP) && last_byte && (bit_cnt == '0);
  assign take      = armed && byte_valid;
  assign bad_stop  = FRAME_CHECK && take && !stop_ok;
  assign good_byte = take && !bad_stop;
  assign finish_ok = good_byte && (rx_cnt == 2'(NUM_RESULT_BYTES - 1));
  assign tmo       = armed && !take && (tcnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_TX_START;
      ST_TX_START: if (bit_end) state_nxt = ST_TX_DATA;
      ST_TX_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_TX_STOP;
      ST_TX_STOP:  if (bit_end) state_nxt = last_byte ? ST_RX_WAIT : ST_TX_START;
      default:     ;
    endcase
    if (finish_ok || tmo || bad_stop) state_nxt = ST_IDLE;
    if (state == ST_TX_START)     tx_nxt = 1'b0;
    else if (state == ST_TX_DATA) tx_nxt = tx_buf[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0; bit_idx <= '0; byte_idx <= '0; tx_buf <= '0;
      armed <= 1'b0; rx_cnt <= '0; shadow <= '0; tcnt <= '0;
      busy <= 1'b0; done <= 1'b0; timeout_err <= 1'b0; frame_err <= 1'b0;
      c_flat <= '0; tx_serial <= 1'b1;
    end else begin
      tx_serial   <= tx_nxt;
      busy        <= (state_nxt != ST_IDLE);
      done        <= finish_ok || tmo || bad_stop;
      timeout_err <= tmo;
      frame_err   <= bad_stop;
      if (state == ST_IDLE && start) begin
        tx_buf   <= {b_flat, a_flat};
        bit_cnt  <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
        rx_cnt   <= '0;
      end else if (state inside {ST_TX_START, ST_TX_DATA, ST_TX_STOP}) begin
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
        if (state == ST_TX_DATA && bit_end) begin
          tx_buf  <= {1'b0, tx_buf[63:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        if (state == ST_TX_STOP && bit_end) byte_idx <= byte_idx + 1'b1;
      end
      if (state_nxt == ST_IDLE) armed <= 1'b0;
      else if (arm_now)         armed <= 1'b1;
      if (arm_now || good_byte) tcnt <= '0;
      else if (armed)           tcnt <= tcnt + 1'b1;
      if (good_byte) begin
        rx_cnt <= rx_cnt + 1'b1;
        case (rx_cnt)
          2'd0:    shadow[7:0]   <= byte_data;
          2'd1:    shadow[15:8]  <= byte_data;
          2'd2:    shadow[23:16] <= byte_data;
          default: ;
        endcase
      end
      // Result word only changes as a whole, on the final byte.
      if (finish_ok) c_flat <= {byte_data, shadow};
    end
  end
endmodule
